// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared states, opcodes, select encodings and EXEC control vector for exec_sequencer
package seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_HALT   = 3'd3,
    ST_PAUSE  = 3'd4
  } seq_state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LDR  = 4'h2;
  localparam logic [3:0] OP_STR  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_JC   = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_JR   = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hE;
  localparam logic [3:0] OP_ILL  = 4'hF;

  localparam logic [1:0] SEL_ACC_ALU = 2'b00;
  localparam logic [1:0] SEL_ACC_RF  = 2'b01;
  localparam logic [1:0] SEL_ACC_IMM = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] SH_NONE  = 2'b00;
  localparam logic [1:0] SH_LEFT  = 2'b01;
  localparam logic [1:0] SH_RIGHT = 2'b10;

  // Which registered flag (if any) gates LoadPC in EXEC
  typedef enum logic [1:0] {
    BR_NONE   = 2'd0,
    BR_Z      = 2'd1,
    BR_C      = 2'd2,
    BR_ALWAYS = 2'd3
  } br_sel_t;

  typedef struct packed {
    logic       load_acc;
    logic [1:0] sel_acc;
    logic [3:0] sel_alu;
    logic       load_reg;
    logic       sel_pc;
    br_sel_t    br;
    logic       flag_upd;
    logic       halt;
    logic       illegal;
  } exec_ctrl_t;

endpackage

// File: rtl/seq_decode.sv
// rtl/seq_decode.sv - combinational opcode to EXEC strobe/select vector and branch-condition select
module seq_decode
  import seq_pkg::*;
(
  input  logic [3:0] opcode,
  output exec_ctrl_t ctrl
);

  // Opcode table; anything not listed (NOP) leaves every field at zero
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_LDI: begin ctrl.load_acc = 1'b1; ctrl.sel_acc = SEL_ACC_IMM; end
      OP_LDR: begin ctrl.load_acc = 1'b1; ctrl.sel_acc = SEL_ACC_RF; end
      OP_STR: ctrl.load_reg = 1'b1;
      OP_ADD: begin ctrl.load_acc = 1'b1; ctrl.flag_upd = 1'b1; ctrl.sel_alu = {ALU_ADD, SH_NONE}; end
      OP_SUB: begin ctrl.load_acc = 1'b1; ctrl.flag_upd = 1'b1; ctrl.sel_alu = {ALU_SUB, SH_NONE}; end
      OP_AND: begin ctrl.load_acc = 1'b1; ctrl.flag_upd = 1'b1; ctrl.sel_alu = {ALU_AND, SH_NONE}; end
      OP_OR:  begin ctrl.load_acc = 1'b1; ctrl.flag_upd = 1'b1; ctrl.sel_alu = {ALU_OR, SH_NONE}; end
      OP_SHL: begin ctrl.load_acc = 1'b1; ctrl.flag_upd = 1'b1; ctrl.sel_alu = {ALU_ADD, SH_LEFT}; end
      OP_SHR: begin ctrl.load_acc = 1'b1; ctrl.flag_upd = 1'b1; ctrl.sel_alu = {ALU_ADD, SH_RIGHT}; end
      OP_JZ:  ctrl.br = BR_Z;
      OP_JC:  ctrl.br = BR_C;
      OP_JMP: ctrl.br = BR_ALWAYS;
      OP_JR:  begin ctrl.br = BR_ALWAYS; ctrl.sel_pc = 1'b1; end
      OP_HALT: ctrl.halt = 1'b1;
      OP_ILL:  ctrl.illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - fetch/decode/exec sequencer for the accumulator MCU; SEQ_STEP_EN adds single-step PAUSE
module exec_sequencer
  import seq_pkg::*;
(
  input  logic       CLK,
  input  logic       CLR,
  input  logic       inst_valid,
  input  logic [3:0] inst_opcode,
  input  logic       alu_z,
  input  logic       alu_c,
`ifdef SEQ_STEP_EN
  input  logic       step_req,
`endif
  output logic       inst_req,
  output logic       LoadIR,
  output logic       IncPC,
  output logic       LoadPC,
  output logic       SelPC,
  output logic       LoadReg,
  output logic       LoadAcc,
  output logic [1:0] SelAcc,
  output logic [3:0] SelALU,
  output logic       z_q,
  output logic       c_q,
  output logic       halted,
  output logic       illegal,
  output logic [7:0] retired
);

  seq_state_t state, next_state;
  logic [3:0] opcode;
  exec_ctrl_t ctrl;
  logic       br_taken;

  seq_decode u_decode (
    .opcode (opcode),
    .ctrl   (ctrl)
  );

  // Conditions look at the flags as registered before this EXEC
  assign br_taken = (ctrl.br == BR_ALWAYS) ||
                    ((ctrl.br == BR_Z) && z_q) ||
                    ((ctrl.br == BR_C) && c_q);

  // State register
  always_ff @(posedge CLK) begin
    if (CLR) state <= ST_FETCH;
    else     state <= next_state;
  end

  // Opcode is captured only on an accepted fetch, so it is stable through DECODE and EXEC
  always_ff @(posedge CLK) begin
    if (CLR)                                  opcode <= OP_NOP;
    else if ((state == ST_FETCH) && inst_valid) opcode <= inst_opcode;
  end

  // Flags, sticky illegal and retire count all commit at the end of EXEC
  always_ff @(posedge CLK) begin
    if (CLR) begin
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      illegal <= 1'b0;
      retired <= 8'd0;
    end else if (state == ST_EXEC) begin
      if (ctrl.flag_upd) begin
        z_q <= alu_z;
        c_q <= alu_c;
      end
      if (ctrl.illegal) illegal <= 1'b1;
      retired <= retired + 8'd1;
    end
  end

  // Next state and strobes; CLR masks strobes so an aborted instruction has no effect
  always_comb begin
    next_state = state;
    inst_req   = 1'b0;
    LoadIR     = 1'b0;
    IncPC      = 1'b0;
    LoadPC     = 1'b0;
    SelPC      = 1'b0;
    LoadReg    = 1'b0;
    LoadAcc    = 1'b0;
    SelAcc     = SEL_ACC_ALU;
    SelALU     = 4'b0000;
    halted     = 1'b0;
    case (state)
      ST_FETCH: begin
        inst_req = 1'b1;
        if (inst_valid) begin
          LoadIR     = !CLR;
          IncPC      = !CLR;
          next_state = ST_DECODE;
        end
      end
      ST_DECODE: next_state = ST_EXEC;
      ST_EXEC: begin
        if (!CLR) begin
          LoadAcc = ctrl.load_acc;
          SelAcc  = ctrl.sel_acc;
          SelALU  = ctrl.sel_alu;
          LoadReg = ctrl.load_reg;
          LoadPC  = br_taken;
          SelPC   = ctrl.sel_pc;
        end
`ifdef SEQ_STEP_EN
        next_state = ctrl.halt ? ST_HALT : ST_PAUSE;
`else
        next_state = ctrl.halt ? ST_HALT : ST_FETCH;
`endif
      end
      ST_HALT: halted = 1'b1;
`ifdef SEQ_STEP_EN
      ST_PAUSE: begin
        if (step_req) next_state = ST_FETCH;
      end
`endif
      default: next_state = ST_FETCH;
    endcase
  end

endmodule
